// File: rtl/control_unit_pkg.sv
// Shared decode constants for the RV32I control unit: opcodes, select encodings, control bundle.
package control_unit_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALU_W    = 4;

    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [ALU_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_PASS_B = 4'b1111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic                pc_sel;
        imm_sel_e            imm_sel;
        logic                reg_wen;
        logic                br_un;
        logic                alu_src1;
        logic                alu_src2;
        logic [ALU_W-1:0]    alu_sel;
        logic                mem_rw;
        logic [FUNCT3_W-1:0] ld_u;
        wb_sel_e             wb_sel;
    } ctrl_t;

    // FENCE and SYSTEM are legal encodings even though the core treats them as NOPs.
    function automatic logic opcode_defined(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM:
                opcode_defined = 1'b1;
            default:
                opcode_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_branch_resolve.sv
// Branch condition resolution from funct3 and the comparator flags.
module control_unit_branch_resolve
    import control_unit_pkg::*;
(
    input  logic [FUNCT3_W-1:0] funct3_i,
    input  logic                br_eq_i,
    input  logic                br_lt_i,
    output logic                taken_o,
    output logic                br_un_o,
    output logic                defined_o
);

    assign br_un_o = funct3_i[1];

    always_comb begin
        taken_o   = 1'b0;
        defined_o = 1'b1;
        case (funct3_i)
            3'b000:         taken_o = br_eq_i;
            3'b001:         taken_o = ~br_eq_i;
            3'b100, 3'b110: taken_o = br_lt_i;
            3'b101, 3'b111: taken_o = ~br_lt_i;
            default:        defined_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Single-cycle RV32I main decoder. Define CONTROL_ILLEGAL_FLAG_EN to add the sticky
// illegal_instr register; otherwise clk and rst are unused.
module control_unit
    import control_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               BrEq,
    input  logic               BrLT,
    output logic               PCSel,
    output logic [2:0]         ImmSel,
    output logic               RegWEn,
    output logic               BrUn,
    output logic               ALUsrc1,
    output logic               ALUsrc2,
    output logic [ALU_W-1:0]   AluSEL,
    output logic               MemRw,
    output logic [2:0]         ldU,
    output logic [1:0]         WBSel
`ifdef CONTROL_ILLEGAL_FLAG_EN
    ,
    output logic               illegal_instr
`endif
);

    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                br_taken;
    logic                br_un;
    logic                br_defined;
    ctrl_t               ctrl_c;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    control_unit_branch_resolve u_branch_resolve (
        .funct3_i  (funct3),
        .br_eq_i   (BrEq),
        .br_lt_i   (BrLT),
        .taken_o   (br_taken),
        .br_un_o   (br_un),
        .defined_o (br_defined)
    );

    // Main decode; unlisted opcodes fall through to the NOP defaults.
    always_comb begin
        ctrl_c        = '0;
        ctrl_c.wb_sel = WB_ALU;
        case (opcode)
            OPC_OP: begin
                ctrl_c.reg_wen = 1'b1;
                ctrl_c.alu_sel = {instr[30], funct3};
            end
            OPC_OP_IMM: begin
                ctrl_c.reg_wen  = 1'b1;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.alu_sel  = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
            end
            OPC_LOAD: begin
                ctrl_c.reg_wen  = 1'b1;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.ld_u     = funct3;
                ctrl_c.wb_sel   = WB_MEM;
            end
            OPC_STORE: begin
                ctrl_c.imm_sel  = IMM_S;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.mem_rw   = 1'b1;
                ctrl_c.ld_u     = funct3;
            end
            OPC_BRANCH: begin
                ctrl_c.imm_sel  = IMM_B;
                ctrl_c.alu_src1 = 1'b1;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.br_un    = br_un;
                ctrl_c.pc_sel   = br_taken;
            end
            OPC_JAL: begin
                ctrl_c.pc_sel   = 1'b1;
                ctrl_c.imm_sel  = IMM_J;
                ctrl_c.alu_src1 = 1'b1;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.reg_wen  = 1'b1;
                ctrl_c.wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                ctrl_c.pc_sel   = 1'b1;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.reg_wen  = 1'b1;
                ctrl_c.wb_sel   = WB_PC4;
            end
            OPC_LUI: begin
                ctrl_c.imm_sel  = IMM_U;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.alu_sel  = ALU_PASS_B;
                ctrl_c.reg_wen  = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_c.imm_sel  = IMM_U;
                ctrl_c.alu_src1 = 1'b1;
                ctrl_c.alu_src2 = 1'b1;
                ctrl_c.reg_wen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCSel   = ctrl_c.pc_sel;
    assign ImmSel  = ctrl_c.imm_sel;
    assign RegWEn  = ctrl_c.reg_wen;
    assign BrUn    = ctrl_c.br_un;
    assign ALUsrc1 = ctrl_c.alu_src1;
    assign ALUsrc2 = ctrl_c.alu_src2;
    assign AluSEL  = ctrl_c.alu_sel;
    assign MemRw   = ctrl_c.mem_rw;
    assign ldU     = ctrl_c.ld_u;
    assign WBSel   = ctrl_c.wb_sel;

    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[31], instr[29:15], instr[11:7]};

`ifdef CONTROL_ILLEGAL_FLAG_EN
    logic illegal_q;
    logic illegal_d;
    logic bad_c;

    assign bad_c = (instr[1:0] != 2'b11) || !opcode_defined(opcode) ||
                   ((opcode == OPC_BRANCH) && !br_defined);

    always_comb begin
        illegal_d = illegal_q | bad_c;
    end

    // Sticky flag; reset takes priority over a same-edge set.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_instr = illegal_q;
`else
    logic unused_cfg;
    assign unused_cfg = &{1'b0, clk, rst, br_defined};
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected decode vectors queued at drive time, popped on sample.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        BrEq;
    logic        BrLT;
    logic        PCSel;
    logic [2:0]  ImmSel;
    logic        RegWEn;
    logic        BrUn;
    logic        ALUsrc1;
    logic        ALUsrc2;
    logic [3:0]  AluSEL;
    logic        MemRw;
    logic [2:0]  ldU;
    logic [1:0]  WBSel;
`ifdef CONTROL_ILLEGAL_FLAG_EN
    logic        illegal_instr;
`endif

    always #5 clk = ~clk;

    control_unit dut (
        .clk     (clk),
        .rst     (rst),
        .instr   (instr),
        .BrEq    (BrEq),
        .BrLT    (BrLT),
        .PCSel   (PCSel),
        .ImmSel  (ImmSel),
        .RegWEn  (RegWEn),
        .BrUn    (BrUn),
        .ALUsrc1 (ALUsrc1),
        .ALUsrc2 (ALUsrc2),
        .AluSEL  (AluSEL),
        .MemRw   (MemRw),
        .ldU     (ldU),
        .WBSel   (WBSel)
`ifdef CONTROL_ILLEGAL_FLAG_EN
        ,
        .illegal_instr (illegal_instr)
`endif
    );

    // {PCSel, ImmSel, RegWEn, BrUn, ALUsrc1, ALUsrc2, AluSEL, MemRw, ldU, WBSel}
    logic [17:0] obs;
    assign obs = {PCSel, ImmSel, RegWEn, BrUn, ALUsrc1, ALUsrc2, AluSEL, MemRw, ldU, WBSel};

    logic [17:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [17:0] mk(input logic pc, input logic [2:0] imm, input logic rw,
                                       input logic bu, input logic s1, input logic s2,
                                       input logic [3:0] alu, input logic mem,
                                       input logic [2:0] ldu, input logic [1:0] wb);
        return {pc, imm, rw, bu, s1, s2, alu, mem, ldu, wb};
    endfunction

    localparam logic [17:0] NOP = 18'b0_000_0_0_0_0_0000_0_000_01;

    task automatic drive(input logic [31:0] i, input logic eq, input logic lt,
                         input logic [17:0] e, input string nm);
        @(negedge clk);
        instr = i;
        BrEq  = eq;
        BrLT  = lt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        string nm;
        @(negedge clk);
        rst = 1'b1;
        drive(32'h00400793, 1'b0, 1'b0, mk(0,3'b000,1,0,0,1,4'h0,0,3'b000,2'b01), "addi_under_rst");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
`ifdef CONTROL_ILLEGAL_FLAG_EN
        @(negedge clk);
        n_cmp++;
        if (illegal_instr !== 1'b0) begin
            n_err++; $display("FAIL illegal_after_rst: got %b want 0", illegal_instr);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] ins [6] = '{32'h00400793, 32'h40C58533, 32'h4020D093,
                                 32'h4000E093, 32'h00B57533, 32'h123450B7};
        logic [17:0] exv [6];
        logic [17:0] e;
        string nm;
        exv[0] = mk(0,3'b000,1,0,0,1,4'h0,0,3'b000,2'b01);
        exv[1] = mk(0,3'b000,1,0,0,0,4'h8,0,3'b000,2'b01);
        exv[2] = mk(0,3'b000,1,0,0,1,4'hD,0,3'b000,2'b01);
        exv[3] = mk(0,3'b000,1,0,0,1,4'h6,0,3'b000,2'b01);
        exv[4] = mk(0,3'b000,1,0,0,0,4'h7,0,3'b000,2'b01);
        exv[5] = mk(0,3'b011,1,0,0,1,4'hF,0,3'b000,2'b01);
        for (int k = 0; k < 6; k++) begin
            drive(ins[k], 1'b0, 1'b0, exv[k], $sformatf("alu_%0d_%08h", k, ins[k]));
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        end
        drive(32'h00001097, 1'b1, 1'b1, mk(0,3'b011,1,0,1,1,4'h0,0,3'b000,2'b01), "auipc");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
    endtask

    task automatic test_mem();
        logic [17:0] e;
        string nm;
        drive(32'hFEF42623, 1'b0, 1'b1, mk(0,3'b001,0,0,0,1,4'h0,1,3'b010,2'b01), "sw");
        drive(32'h00458603, 1'b0, 1'b0, mk(0,3'b000,1,0,0,1,4'h0,0,3'b000,2'b00), "lb");
        drive(32'h0045A603, 1'b0, 1'b0, mk(0,3'b000,1,0,0,1,4'h0,0,3'b010,2'b00), "lw");
        drive(32'h0045D603, 1'b1, 1'b0, mk(0,3'b000,1,0,0,1,4'h0,0,3'b101,2'b00), "lhu");
        // Drives were queued back to back; only the last one is still on the bus.
        while (exp_q.size() > 1) begin
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        drive(32'hFEF42623, 1'b0, 1'b1, mk(0,3'b001,0,0,0,1,4'h0,1,3'b010,2'b01), "sw_again");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        drive(32'h00458603, 1'b0, 1'b0, mk(0,3'b000,1,0,0,1,4'h0,0,3'b000,2'b00), "lb_again");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        drive(32'h0045A603, 1'b0, 1'b0, mk(0,3'b000,1,0,0,1,4'h0,0,3'b010,2'b00), "lw_again");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
    endtask

    task automatic test_branch();
        logic [31:0] ins [12] = '{32'h00058663, 32'h00058663, 32'h00059663, 32'h00059663,
                                  32'h0005C663, 32'h0005E663, 32'h0005E663, 32'h0005D663,
                                  32'h0005D663, 32'h0005F663, 32'h0005A663, 32'h0005B663};
        logic        eqs [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        lts [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        pcs [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        bus [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [17:0] e;
        string nm;
        for (int k = 0; k < 12; k++) begin
            drive(ins[k], eqs[k], lts[k], mk(pcs[k],3'b010,0,bus[k],1,1,4'h0,0,3'b000,2'b01),
                  $sformatf("br_%08h_eq%0d_lt%0d", ins[k], eqs[k], lts[k]));
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        end
    endtask

    task automatic test_jump();
        logic [17:0] e;
        string nm;
        drive(32'h008000EF, 1'b0, 1'b0, mk(1,3'b100,1,0,1,1,4'h0,0,3'b000,2'b10), "jal");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        drive(32'h000080E7, 1'b1, 1'b1, mk(1,3'b000,1,0,0,1,4'h0,0,3'b000,2'b10), "jalr");
        e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
    endtask

    task automatic test_nop();
        logic [31:0] ins [5] = '{32'h00000073, 32'h0FF0000F, 32'h0000007F, 32'h00000000, 32'hFFFFFFFF};
        logic [17:0] e;
        string nm;
        for (int k = 0; k < 5; k++) begin
            drive(ins[k], 1'b1, 1'b1, NOP, $sformatf("nop_%08h", ins[k]));
            e = exp_q.pop_front(); nm = name_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_err++; $display("FAIL %s: got %05h want %05h", nm, obs, e); end
        end
    endtask

`ifdef CONTROL_ILLEGAL_FLAG_EN
    task automatic test_illegal();
        logic [31:0] ins [9] = '{32'h0000007F, 32'h00400793, 32'h0000007F, 32'h00400793,
                                 32'h0000007F, 32'h0005A663, 32'h00000073, 32'h00000010,
                                 32'h0FF0000F};
        logic        rs  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        exf [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            instr = ins[k];
            rst   = rs[k];
            @(negedge clk);
            n_cmp++;
            if (illegal_instr !== exf[k]) begin
                n_err++;
                $display("FAIL illegal_step%0d_%08h_rst%0d: got %b want %b",
                         k, ins[k], rs[k], illegal_instr, exf[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst   = 1'b0;
        instr = 32'h00000013;
        BrEq  = 1'b0;
        BrLT  = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_jump();
        test_nop();
`ifdef CONTROL_ILLEGAL_FLAG_EN
        test_illegal();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
